gt_compare_checker: RTL
=======================

// Module: gt_compare_checker
// PURPOSE
//  Response-side checker for the N-bit greater-than comparator; it is the consuming end of the vector stream a stimulus source drives.
//  Accepts observed (a, b, f) triples over a valid/ready handshake and checks f against the golden a > b.
//  Tracks which of the 2^(2N) input combinations have been seen and counts vectors and mismatches.
//  Declares done/pass once every combination has been covered. Used in benches and as on-board self-test for the 2-/4-bit comparators.
// PARAMETERS
//  WIDTH      2  operand width in bits (legal 1..4); coverage map has 2^(2*WIDTH) entries
//  ERR_CNT_W  8  width of err_cnt; saturates at all-ones
//  VEC_CNT_W 16  width of vec_cnt; saturates at all-ones
// PORTS
//  clk         in  1              clock, rising edge
//  rst         in  1              asynchronous, active-high reset
//  start       in  1              1-cycle pulse: clear all state and enter RUN
//  obs_valid   in  1              observed triple is valid this cycle
//  obs_ready   out 1              checker accepts a triple (1 only in RUN)
//  obs_a       in  WIDTH          operand a applied to DUT
//  obs_b       in  WIDTH          operand b applied to DUT
//  obs_f       in  1              DUT output
//  mismatch    out 1              1-cycle pulse: the previously accepted triple failed
//  err_cnt     out ERR_CNT_W      number of failing triples
//  vec_cnt     out VEC_CNT_W      number of accepted triples, duplicates included
//  cov_cnt     out 2*WIDTH+1      number of distinct {a,b} combinations seen
//  fail_valid  out 1              first-failure capture is valid
//  fail_a      out WIDTH          a of first failing triple
//  fail_b      out WIDTH          b of first failing triple
//  fail_f      out 1              f of first failing triple
//  done        out 1              coverage complete (or halted); level while in DONE
//  pass        out 1              done && err_cnt==0
// BEHAVIOUR
//  Reset (async): state=IDLE; every output 0; coverage map cleared.
//  FSM states and transitions:
//   IDLE -start-> RUN
//   RUN -start-> RUN (restart)
//   RUN -coverage full-> DONE
//   DONE -start-> RUN
//  start (any state): next cycle the map, err_cnt, vec_cnt, cov_cnt and fail_* are 0, and state=RUN.
//  obs_ready = (state==RUN). A handshake is obs_valid && obs_ready. obs_valid in IDLE or DONE is ignored; no counter changes.
//  On a handshake: exp = (obs_a > obs_b), unsigned. Then, registered on the same edge:
//   - vec_cnt+1 (saturating)
//   - if map[{a,b}]==0: set it and cov_cnt+1
//   - if obs_f!=exp: mismatch=1 for 1 cycle, err_cnt+1 (saturating)
//   - if obs_f!=exp and fail_valid==0: capture fail_a/b/f and set fail_valid
//  Latency: mismatch and counters update 1 cycle after the handshake edge.
//  Duplicate {a,b}: still checked and counted in vec_cnt and err_cnt; map and cov_cnt unchanged.
//  Coverage full: when the handshake sets the last map bit, state=DONE on that same edge.
//   - done=1 and obs_ready=0 from the next cycle; pass=(err_cnt==0) including that final triple.
//  start and obs_valid in the same RUN cycle: start wins; the triple is dropped and not counted.
//  rst mid-RUN: immediate return to the reset values; no partial results are retained.
//  Outputs hold stable in DONE until start or rst.
// CONFIGURATION
//  GT_CHK_HALT_ON_FAIL_EN defined:
//   - the first mismatching handshake moves the FSM to DONE on the same edge, with done=1, pass=0, and fail_* captured.
//   - cov_cnt reflects coverage up to and including that triple.
//  GT_CHK_HALT_ON_FAIL_EN undefined: checking continues to full coverage regardless of errors.
// TESTING (WIDTH=2, 16 combinations)
//  1. Reset then start; drive all 16 {a,b} with correct f, one per cycle -> done=1 and pass=1 the cycle after the 16th; err_cnt=0, vec_cnt=16, cov_cnt=16.
//  2. As 1, but a=2'b10, b=2'b01 sent with f=0 -> mismatch pulse one cycle later; err_cnt=1, fail_valid=1, fail_a=2, fail_b=1, fail_f=0; at end done=1, pass=0.
//  3. 20 handshakes with 4 duplicates, valid gaps between them, and pulses in IDLE before start -> IDLE pulses ignored; vec_cnt=20, cov_cnt=16; done only after the 16th distinct pair.
//  4. Assert rst after 7 vectors, then start and send 16 good vectors -> all counts restart from 0; pass=1, vec_cnt=16.
//  5. start in the same cycle as a valid triple during RUN -> triple dropped; vec_cnt=0 next cycle.
//  6. GT_CHK_HALT_ON_FAIL_EN defined: 3rd vector wrong -> done=1, pass=0, vec_cnt=3, obs_ready=0 afterwards.

Source files
------------

// File: rtl/gt_compare_checker.sv
// Response-side checker for an N-bit greater-than comparator: checks observed (a,b,f)
// triples against a > b and tracks coverage. Optional macro: GT_CHK_HALT_ON_FAIL_EN.
module gt_compare_checker #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned VEC_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   obs_valid,
    output logic                   obs_ready,
    input  logic [WIDTH-1:0]       obs_a,
    input  logic [WIDTH-1:0]       obs_b,
    input  logic                   obs_f,
    output logic                   mismatch,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [VEC_CNT_W-1:0]   vec_cnt,
    output logic [2*WIDTH:0]       cov_cnt,
    output logic                   fail_valid,
    output logic [WIDTH-1:0]       fail_a,
    output logic [WIDTH-1:0]       fail_b,
    output logic                   fail_f,
    output logic                   done,
    output logic                   pass
);
    localparam int unsigned IDX_W = 2 * WIDTH;
    localparam int unsigned NCOMB = 1 << IDX_W;
    localparam int unsigned COV_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NCOMB-1:0]       map_q, map_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;
    logic [VEC_CNT_W-1:0]   vec_q, vec_d;
    logic [COV_W-1:0]       cov_q, cov_d;
    logic                   mis_q, mis_d;
    logic                   fv_q, fv_d;
    logic [WIDTH-1:0]       fa_q, fa_d;
    logic [WIDTH-1:0]       fb_q, fb_d;
    logic                   ff_q, ff_d;

    logic                   handshake;
    logic                   expected;
    logic                   bad;
    logic [IDX_W-1:0]       idx;

    assign handshake = obs_valid && (state_q == RUN);
    assign expected  = (obs_a > obs_b);
    assign bad       = (obs_f != expected);
    assign idx       = {obs_a, obs_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            map_q   <= '0;
            err_q   <= '0;
            vec_q   <= '0;
            cov_q   <= '0;
            mis_q   <= 1'b0;
            fv_q    <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            ff_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            map_q   <= map_d;
            err_q   <= err_d;
            vec_q   <= vec_d;
            cov_q   <= cov_d;
            mis_q   <= mis_d;
            fv_q    <= fv_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            ff_q    <= ff_d;
        end
    end

    always_comb begin
        state_d = state_q;
        map_d   = map_q;
        err_d   = err_q;
        vec_d   = vec_q;
        cov_d   = cov_q;
        mis_d   = 1'b0;
        fv_d    = fv_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        ff_d    = ff_q;

        // start outranks a simultaneous handshake: the triple is dropped
        if (start) begin
            state_d = RUN;
            map_d   = '0;
            err_d   = '0;
            vec_d   = '0;
            cov_d   = '0;
            fv_d    = 1'b0;
            fa_d    = '0;
            fb_d    = '0;
            ff_d    = 1'b0;
        end else if (handshake) begin
            if (!(&vec_q)) begin
                vec_d = vec_q + VEC_CNT_W'(1);
            end
            if (!map_q[idx]) begin
                map_d[idx] = 1'b1;
                cov_d      = cov_q + COV_W'(1);
            end
            if (bad) begin
                mis_d = 1'b1;
                if (!(&err_q)) begin
                    err_d = err_q + ERR_CNT_W'(1);
                end
                if (!fv_q) begin
                    fv_d = 1'b1;
                    fa_d = obs_a;
                    fb_d = obs_b;
                    ff_d = obs_f;
                end
            end
            if (&map_d) begin
                state_d = DONE;
            end
`ifdef GT_CHK_HALT_ON_FAIL_EN
            if (bad) begin
                state_d = DONE;
            end
`endif
        end
    end

    assign obs_ready  = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign mismatch   = mis_q;
    assign err_cnt    = err_q;
    assign vec_cnt    = vec_q;
    assign cov_cnt    = cov_q;
    assign fail_valid = fv_q;
    assign fail_a     = fa_q;
    assign fail_b     = fb_q;
    assign fail_f     = ff_q;

endmodule
